// File: rtl/mem_access_unit_if.sv
// Bus port bundle between mem_access_unit and the data memory / bus fabric.
// Request: valid/ready plus addr/we/wstrb/wdata. Response: rsp_valid plus rdata.
interface mem_access_unit_if;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic [31:0] bus_addr;
   logic        bus_we;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_rsp_valid;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req_valid,
      output bus_addr,
      output bus_we,
      output bus_wstrb,
      output bus_wdata,
      input  bus_req_ready,
      input  bus_rsp_valid,
      input  bus_rdata
   );

   modport slave (
      input  bus_req_valid,
      input  bus_addr,
      input  bus_we,
      input  bus_wstrb,
      input  bus_wdata,
      output bus_req_ready,
      output bus_rsp_valid,
      output bus_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns the pipeline access into one bus transaction.
// Ports: clk/reset; pipeline MemReadM/MemWriteM/funct3M/ALUResultM/WriteDataM in;
// load_data/stall_mem/misaligned out; bus = master side of mem_access_unit_if.
module mem_access_unit (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     MemReadM,
   input  logic                     MemWriteM,
   input  logic [2:0]               funct3M,
   input  logic [31:0]              ALUResultM,
   input  logic [31:0]              WriteDataM,
   output logic [31:0]              load_data,
   output logic                     stall_mem,
   output logic                     misaligned,
   mem_access_unit_if.master        bus
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] load_data_q, load_data_d;

   logic        access;
   logic        is_store;
   logic [1:0]  off;
   logic        addr_bad;
   logic [3:0]  strb;
   logic [31:0] wdata;
   logic [31:0] rd_b_sh;
   logic [31:0] rd_h_sh;
   logic [7:0]  rd_b;
   logic [15:0] rd_h;
   logic [31:0] ext;
   logic        req_valid;

   // A store wins when both enables are high.
   assign access   = MemReadM | MemWriteM;
   assign is_store = MemWriteM;
   assign off      = ALUResultM[1:0];

   always_comb begin
      addr_bad = 1'b0;
      unique case (funct3M[1:0])
         2'b01:   addr_bad = off[0];
         2'b10:   addr_bad = |off;
         default: addr_bad = 1'b0;
      endcase
   end

   // Narrow stores replicate data across all lanes; strobes pick the lane.
   always_comb begin
      strb  = 4'b1111;
      wdata = WriteDataM;
      unique case (funct3M)
         3'b000: begin
            strb  = 4'b0001 << off;
            wdata = {4{WriteDataM[7:0]}};
         end
         3'b001: begin
            strb  = off[1] ? 4'b1100 : 4'b0011;
            wdata = {2{WriteDataM[15:0]}};
         end
         default: begin
            strb  = 4'b1111;
            wdata = WriteDataM;
         end
      endcase
   end

   assign rd_b_sh = bus.bus_rdata >> {off, 3'b000};
   assign rd_h_sh = bus.bus_rdata >> {off[1], 4'b0000};
   assign rd_b    = rd_b_sh[7:0];
   assign rd_h    = rd_h_sh[15:0];

   always_comb begin
      ext = bus.bus_rdata;
      unique case (funct3M)
         3'b000:  ext = {{24{rd_b[7]}}, rd_b};
         3'b001:  ext = {{16{rd_h[15]}}, rd_h};
         3'b100:  ext = {24'h000000, rd_b};
         3'b101:  ext = {16'h0000, rd_h};
         default: ext = bus.bus_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      load_data_d = load_data_q;
      stall_mem   = 1'b0;
      misaligned  = 1'b0;
      req_valid   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (access) begin
               if (addr_bad) begin
                  misaligned = 1'b1;
               end else begin
                  stall_mem = 1'b1;
                  state_d   = REQ;
               end
            end
         end
         REQ: begin
            req_valid = 1'b1;
            stall_mem = 1'b1;
            if (bus.bus_req_ready) begin
               state_d = is_store ? DONE : WAIT;
            end
         end
         WAIT: begin
            stall_mem = 1'b1;
            if (bus.bus_rsp_valid) begin
               load_data_d = ext;
               state_d     = DONE;
            end
         end
         DONE: begin
            // Pipeline advances at the end of this cycle; never re-issue here.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request fields come straight from EX/MEM, which is frozen while stalled.
   assign bus.bus_req_valid = req_valid;
   assign bus.bus_addr      = {ALUResultM[31:2], 2'b00};
   assign bus.bus_we        = req_valid & is_store;
   assign bus.bus_wstrb     = req_valid ? strb : 4'b0000;
   assign bus.bus_wdata     = wdata;
   assign load_data         = load_data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         load_data_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         load_data_q <= load_data_d;
      end
   end

endmodule
